// File: rtl/jtframe_status_rx.sv
// rtl/jtframe_status_rx.sv - byte-serial OSD status frame receiver with atomic commit
//
// Collects a status frame one byte at a time into a shadow register. On frame end
// it merges the received bytes into the 64-bit status word in a single cycle.
// Bytes that were not received keep their old value.
//
// Ports:
//   rst_n       async active-low reset
//   clk         system clock
//   cmd_start   pulse, begin a frame
//   cmd_end     pulse, commit the frame
//   data_stb    pulse, data_in valid
//   data_in     status byte, first byte lands in status[7:0]
//   status      committed status word
//   status_upd  pulse on every commit
//   status_chg  pulse on a commit that changed status
//   frame_err   pulse when a frame is discarded (timeout or restart)
//   busy        high while loading or committing
module jtframe_status_rx #(
    parameter int          NBYTES     = 8,
    parameter int          TOUT_W     = 12,
    parameter logic [63:0] RST_STATUS = 64'd0
) (
    input  logic        rst_n,
    input  logic        clk,
    input  logic        cmd_start,
    input  logic        cmd_end,
    input  logic        data_stb,
    input  logic [7:0]  data_in,
    output logic [63:0] status,
    output logic        status_upd,
    output logic        status_chg,
    output logic        frame_err,
    output logic        busy
);

    localparam int CNT_W = $clog2(NBYTES + 1);
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] NB_C = CNT_W'(NBYTES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        count_q;
    logic [NBYTES-1:0]       mask_q;
    logic [TOUT_W-1:0]       tout_q;
    logic [NBYTES*8-1:0]     shadow_q;
    logic [63:0]             merged;
    logic [IDX_W-1:0]        wr_idx;
    logic                    room;

    assign room   = (count_q < NB_C);
    assign wr_idx = count_q[IDX_W-1:0];

    // Byte-wise merge: only bytes received in this frame replace the old status.
    always_comb begin
        merged = status;
        for (int i = 0; i < NBYTES; i++) begin
            if (mask_q[i]) merged[i*8 +: 8] = shadow_q[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            mask_q     <= '0;
            tout_q     <= '0;
            shadow_q   <= '0;
            status     <= RST_STATUS;
            status_upd <= 1'b0;
            status_chg <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            status_upd <= 1'b0;
            status_chg <= 1'b0;
            frame_err  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_start) begin
                        state_q <= ST_LOAD;
                        count_q <= '0;
                        mask_q  <= '0;
                        tout_q  <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (cmd_start) begin
                        // Restart wins over everything, including a coincident byte.
                        frame_err <= 1'b1;
                        count_q   <= '0;
                        mask_q    <= '0;
                        tout_q    <= '0;
                    end else begin
                        if (data_stb && room) begin
                            shadow_q[{wr_idx, 3'b000} +: 8] <= data_in;
                            mask_q[wr_idx] <= 1'b1;
                            count_q        <= count_q + CNT_W'(1);
                        end
                        tout_q <= data_stb ? '0 : tout_q + TOUT_W'(1);
                        if (cmd_end) begin
                            // Empty frame (counting a byte arriving with cmd_end) is dropped silently.
                            if (mask_q == '0 && !(data_stb && room)) begin
                                state_q <= ST_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                state_q <= ST_COMMIT;
                            end
                        end else if (!data_stb && (&tout_q)) begin
                            frame_err <= 1'b1;
                            state_q   <= ST_IDLE;
                            busy      <= 1'b0;
                        end
                    end
                end
                ST_COMMIT: begin
                    status     <= merged;
                    status_upd <= 1'b1;
                    status_chg <= (merged != status);
                    if (cmd_start) begin
                        state_q <= ST_LOAD;
                        count_q <= '0;
                        mask_q  <= '0;
                        tout_q  <= '0;
                        busy    <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_status_rx.sv
// tb/tb_jtframe_status_rx.sv - directed self-checking bench for jtframe_status_rx
module tb_jtframe_status_rx;

    logic        rst_n;
    logic        clk;
    logic        cmd_start;
    logic        cmd_end;
    logic        data_stb;
    logic [7:0]  data_in;
    logic [63:0] status;
    logic        status_upd;
    logic        status_chg;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int upd_seen = 0;
    int chg_seen = 0;
    int err_seen = 0;

    jtframe_status_rx dut (
        .rst_n      (rst_n),
        .clk        (clk),
        .cmd_start  (cmd_start),
        .cmd_end    (cmd_end),
        .data_stb   (data_stb),
        .data_in    (data_in),
        .status     (status),
        .status_upd (status_upd),
        .status_chg (status_chg),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (status_upd) upd_seen++;
        if (status_chg) chg_seen++;
        if (frame_err)  err_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic e, input logic d, input logic [7:0] b);
        cmd_start = s;
        cmd_end   = e;
        data_stb  = d;
        data_in   = b;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        cmd_end   = 1'b0;
        data_stb  = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [63:0] vals);
        logic [63:0] v;
        v = vals;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, v[i*8 +: 8]);
        step(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic commit_expect(input string tag, input logic [63:0] exp, input logic exp_chg);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check({tag, "_status"}, status, exp);
        check({tag, "_upd"}, {63'd0, status_upd}, 64'd1);
        check({tag, "_chg"}, {63'd0, status_chg}, {63'd0, exp_chg});
        check({tag, "_err"}, {63'd0, frame_err}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check({tag, "_upd_off"}, {62'd0, status_upd, status_chg}, 64'd0);
    endtask

    initial begin
        int e0, u0, c0, first;
        rst_n = 1'b0;
        cmd_start = 1'b0;
        cmd_end = 1'b0;
        data_stb = 1'b0;
        data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_status", status, 64'd0);
        check("rst_flags", {60'd0, status_upd, status_chg, frame_err, busy}, 64'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // 8-byte frame; status must hold until the cycle after cmd_end
        send_frame(8, 64'h0807060504030201);
        check("t1_hold_status", status, 64'd0);
        check("t1_hold_busy", {63'd0, busy}, 64'd1);
        commit_expect("t1", 64'h0807060504030201, 1'b1);

        // Same frame, last byte coincident with cmd_end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 7; i++) step(1'b0, 1'b0, 1'b1, 8'(i));
        step(1'b0, 1'b1, 1'b1, 8'h08);
        commit_expect("t2", 64'h0807060504030201, 1'b0);

        // Partial MiST frame preserves upper bytes
        send_frame(8, 64'hFFFF_FFFF_0000_0000);
        commit_expect("t3a", 64'hFFFF_FFFF_0000_0000, 1'b1);
        send_frame(4, 64'h0000_0000_DDCC_BBAA);
        commit_expect("t3b", 64'hFFFF_FFFF_DDCC_BBAA, 1'b1);

        // 10 bytes: the last two are dropped without error
        e0 = err_seen;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h21 + i));
        step(1'b0, 1'b1, 1'b0, 8'h00);
        commit_expect("t6_overflow", 64'h2827262524232221, 1'b1);
        check("t6_overflow_noerr", 64'(err_seen - e0), 64'd0);

        // Timeout after 2 bytes and 4096 idle cycles
        e0 = err_seen;
        u0 = upd_seen;
        first = 0;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b0, 1'b1, 8'h66);
        for (int i = 1; i <= 5000; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            if (frame_err && first == 0) first = i;
            if (first != 0 && i > first + 4) break;
        end
        check("t4_tout_cycle", 64'(first), 64'd4096);
        check("t4_err_count", 64'(err_seen - e0), 64'd1);
        check("t4_no_upd", 64'(upd_seen - u0), 64'd0);
        check("t4_status", status, 64'h2827262524232221);
        check("t4_busy", {63'd0, busy}, 64'd0);

        // Restart mid-frame, coincident byte dropped
        e0 = err_seen;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b0, 1'b1, 8'h33);
        step(1'b1, 1'b0, 1'b1, 8'h99);
        check("t5_err", {63'd0, frame_err}, 64'd1);
        check("t5_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h31 + i));
        step(1'b0, 1'b1, 1'b0, 8'h00);
        commit_expect("t5", 64'h3837363534333231, 1'b1);
        check("t5_err_count", 64'(err_seen - e0), 64'd1);

        // Empty frame: no pulses at all
        e0 = err_seen;
        u0 = upd_seen;
        c0 = chg_seen;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        check("t5_empty_busy", {63'd0, busy}, 64'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
        check("t5_empty_pulses", 64'((err_seen - e0) + (upd_seen - u0) + (chg_seen - c0)), 64'd0);
        check("t5_empty_status", status, 64'h3837363534333231);

        // Async reset mid-LOAD
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h77);
        step(1'b0, 1'b0, 1'b1, 8'h88);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_status", status, 64'd0);
        check("t6_rst_flags", {60'd0, status_upd, status_chg, frame_err, busy}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00);
        check("t6_after_rst", {61'd0, status_upd, frame_err, busy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
